intpol_ctrl_fsm: RTL and testbench
==================================

INTPOL_CTRL_FSM -- requirements
Module: intpol_ctrl_fsm

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, width of the configuration-load address counter.
REQ-002 SHALL have parameter CNT_W, default 8, width of the interpolation-factor and phase counter.
REQ-003 SHALL have parameter OUT_W, default 16, width of the output-sample counter.
REQ-004 Ports (name direction width meaning):
- clk input 1: single clock; all state changes on the rising edge.
- rstn input 1: reset; synchronous, active-low.
- start input 1: start pulse; also aborts any active operation.
- mode input 1: 0 = accelerator (one block), 1 = stream (continuous).
- bypass input 1: skip interpolation after configuration load.
- n_addr input ADDR_W: number of configuration words minus 1.
- factor input CNT_W: interpolation factor L; 0 treated as 1.
- Empty input 1: input FIFO empty.
- Afull input 1: output FIFO almost full.
- busy output 1: operation in progress.
- Read_Enable output 1: pop input FIFO.
- Write_Enable output 1: push output FIFO.
- Ld_data output 1: output sample valid this cycle.
- Ld_p1_xi output 1: load new base sample and slope.
- en_M_addr output 1: configuration address advance.
- addr output ADDR_W: configuration address.
- phase output CNT_W: current interpolation phase.
- en_sum output 1: accumulate slope.
- sel_mult output 1: datapath multiplier select.
- en_stream output 1: waiting for next stream sample.
- stop_empty output 1: stalled on Empty.
- stop_Afull output 1: stalled on Afull.
- done output 1: block-complete pulse.
- clear output 1: datapath clear.
- out_cnt output OUT_W: output samples written since last start.

Function
REQ-005 SHALL implement states IDLE, LOAD, PRIME, INTERP, DONE, STREAM, CLEAR, BYP_ACCEL, BYP_STRM.
REQ-006 In IDLE, start SHALL latch mode, bypass, n_addr and factor (factor 0 latched as 1), zero addr, phase and out_cnt, and go to LOAD; all latched values SHALL stay fixed until the next start.
REQ-007 LOAD SHALL assert busy and Read_Enable.
- If mode=1 and Empty=1: assert stop_empty and hold addr.
- Otherwise: assert en_M_addr and increment addr.
- At addr==n_addr with en_M_addr: wrap addr to 0 and exit to PRIME (bypass=0), BYP_ACCEL (bypass=1, mode=0) or BYP_STRM (bypass=1, mode=1).
REQ-008 PRIME SHALL assert Ld_p1_xi and busy for exactly one cycle, then go to INTERP.
REQ-009 INTERP SHALL assert busy and sel_mult.
- If mode=1 and Afull=1: assert stop_Afull; Ld_data, en_sum and phase SHALL be held.
- Otherwise: assert Ld_data.
- If phase==L-1: set phase to 0 and go to DONE.
- Else: assert en_sum, increment phase and stay in INTERP, giving one output per cycle.
REQ-010 DONE SHALL assert done and busy for one cycle, then go to IDLE if mode=0 or to STREAM if mode=1.
REQ-011 STREAM SHALL assert busy and en_stream.
- If Empty=1: assert stop_empty.
- Else: assert Read_Enable for one cycle and go to PRIME.
- Read_Enable SHALL never assert while Empty=1.
REQ-012 BYP_ACCEL SHALL assert done and busy for one cycle, then go to IDLE.
REQ-013 BYP_STRM SHALL assert busy, stop_empty=Empty and stop_Afull=Afull; Read_Enable SHALL equal !Empty & !Afull; the state SHALL be held until start.
REQ-014 Write_Enable SHALL equal Ld_data delayed by one registered cycle.
REQ-015 out_cnt SHALL increment on every Write_Enable and wrap modulo 2^OUT_W.
REQ-016 clear SHALL be the combinational OR of start and done.
REQ-017 start in any state other than IDLE SHALL abort to CLEAR on the next edge.
- Pending Write_Enable from the prior cycle SHALL still complete.
- addr, phase and out_cnt SHALL be zeroed and the configuration re-latched.
REQ-018 CLEAR SHALL deassert busy and stay while start=1. After start falls:
- mode=1 and Empty=1: assert stop_empty and wait.
- Otherwise: go to LOAD.
REQ-019 Every output not explicitly asserted in a state SHALL be 0.
REQ-020 When stop_empty and stop_Afull conditions coincide in BYP_STRM, both SHALL assert; in INTERP, Empty SHALL be ignored.

Reset
REQ-021 On a rising clk edge with rstn=0:
- state SHALL go to IDLE.
- addr, phase, out_cnt and Write_Enable SHALL be 0, along with all latched configuration.
- Combinational outputs SHALL then evaluate to 0, except clear, which follows start.
REQ-022 Reset SHALL override start on the same edge.
REQ-023 Reset mid-operation SHALL abandon the operation without asserting done.

Verification
REQ-024 Accel, n_addr=3, factor=4, bypass=0, no stalls -> Read_Enable 4 cycles; Ld_p1_xi 1 cycle; Ld_data 4 consecutive cycles with phase 0..3; done 1 cycle; IDLE; out_cnt=4.
REQ-025 Stream, factor=2, Afull=1 for 3 cycles during INTERP -> stop_Afull 3 cycles, phase frozen, no Write_Enable during stall; total 2 writes per input sample.
REQ-026 Stream, Empty=1 in STREAM for 5 cycles -> stop_empty=1, Read_Enable=0 for 5 cycles; then one Read_Enable and PRIME.
REQ-027 factor=0 -> behaves as factor=1: one Ld_data per PRIME.
REQ-028 start asserted mid-INTERP -> CLEAR next edge, clear=1, busy=0, counters zero; LOAD after start falls.
REQ-029 rstn=0 while in BYP_STRM with Read_Enable=1 -> next edge IDLE, all outputs 0, no done pulse.

Source files
------------

// File: rtl/intpol_ctrl_fsm.sv
// Control sequencer for the interpolation datapath: config load, per-sample
// interpolation phases, stream refill and bypass paths, with FIFO flow control.
module intpol_ctrl_fsm #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              mode,
  input  logic              bypass,
  input  logic [ADDR_W-1:0] n_addr,
  input  logic [CNT_W-1:0]  factor,
  input  logic              Empty,
  input  logic              Afull,
  output logic              busy,
  output logic              Read_Enable,
  output logic              Write_Enable,
  output logic              Ld_data,
  output logic              Ld_p1_xi,
  output logic              en_M_addr,
  output logic [ADDR_W-1:0] addr,
  output logic [CNT_W-1:0]  phase,
  output logic              en_sum,
  output logic              sel_mult,
  output logic              en_stream,
  output logic              stop_empty,
  output logic              stop_Afull,
  output logic              done,
  output logic              clear,
  output logic [OUT_W-1:0]  out_cnt
);

  typedef enum logic [3:0] {
    IDLE, LOAD, PRIME, INTERP, DONE, STREAM, CLEAR, BYP_ACCEL, BYP_STRM
  } state_t;

  typedef struct packed {
    logic              mode;
    logic              bypass;
    logic [ADDR_W-1:0] n_addr;
    logic [CNT_W-1:0]  lfac;
  } cfg_t;

  state_t state, state_nxt;
  cfg_t   cfg;
  logic   addr_inc, addr_wrap, ph_inc, ph_wrap;

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    Read_Enable = 1'b0;
    Ld_data     = 1'b0;
    Ld_p1_xi    = 1'b0;
    en_M_addr   = 1'b0;
    en_sum      = 1'b0;
    sel_mult    = 1'b0;
    en_stream   = 1'b0;
    stop_empty  = 1'b0;
    stop_Afull  = 1'b0;
    done        = 1'b0;
    addr_inc    = 1'b0;
    addr_wrap   = 1'b0;
    ph_inc      = 1'b0;
    ph_wrap     = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        busy = 1'b1;
        // in stream mode the config words come through the FIFO, so wait on it
        if (cfg.mode && Empty) begin
          stop_empty = 1'b1;
        end else begin
          Read_Enable = 1'b1;
          en_M_addr   = 1'b1;
          if (addr == cfg.n_addr) begin
            addr_wrap = 1'b1;
            if (!cfg.bypass)  state_nxt = PRIME;
            else if (cfg.mode) state_nxt = BYP_STRM;
            else               state_nxt = BYP_ACCEL;
          end else begin
            addr_inc = 1'b1;
          end
        end
      end
      PRIME: begin
        busy      = 1'b1;
        Ld_p1_xi  = 1'b1;
        state_nxt = INTERP;
      end
      INTERP: begin
        busy     = 1'b1;
        sel_mult = 1'b1;
        if (cfg.mode && Afull) begin
          stop_Afull = 1'b1;
        end else begin
          Ld_data = 1'b1;
          if (phase == cfg.lfac - CNT_W'(1)) begin
            ph_wrap   = 1'b1;
            state_nxt = DONE;
          end else begin
            en_sum = 1'b1;
            ph_inc = 1'b1;
          end
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = cfg.mode ? STREAM : IDLE;
      end
      STREAM: begin
        busy      = 1'b1;
        en_stream = 1'b1;
        if (Empty) begin
          stop_empty = 1'b1;
        end else begin
          Read_Enable = 1'b1;
          state_nxt   = PRIME;
        end
      end
      CLEAR: begin
        if (!start) begin
          if (cfg.mode && Empty) stop_empty = 1'b1;
          else                   state_nxt  = LOAD;
        end
      end
      BYP_ACCEL: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      BYP_STRM: begin
        busy        = 1'b1;
        stop_empty  = Empty;
        stop_Afull  = Afull;
        Read_Enable = !Empty && !Afull;
      end
      default: state_nxt = IDLE;
    endcase
    // start outside IDLE is an abort
    if (start && state != IDLE) state_nxt = CLEAR;
  end

  assign clear = start | done;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      cfg          <= '0;
      addr         <= '0;
      phase        <= '0;
      out_cnt      <= '0;
      Write_Enable <= 1'b0;
    end else begin
      state        <= state_nxt;
      Write_Enable <= Ld_data;
      if (start) begin
        cfg.mode   <= mode;
        cfg.bypass <= bypass;
        cfg.n_addr <= n_addr;
        cfg.lfac   <= (factor == '0) ? CNT_W'(1) : factor;
        addr       <= '0;
        phase      <= '0;
        out_cnt    <= '0;
      end else begin
        if (addr_wrap)     addr  <= '0;
        else if (addr_inc) addr  <= addr + ADDR_W'(1);
        if (ph_wrap)       phase <= '0;
        else if (ph_inc)   phase <= phase + CNT_W'(1);
        if (Write_Enable)  out_cnt <= out_cnt + OUT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_intpol_ctrl_fsm.sv
// Randomized scoreboard bench for intpol_ctrl_fsm: stimulus queues expected
// per-block results, a negedge monitor checks them and cycle-level rules.
module tb_intpol_ctrl_fsm;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 8;
  localparam int OUT_W  = 16;

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, mode = 1'b0, bypass = 1'b0;
  logic Empty = 1'b0, Afull = 1'b0;
  logic [ADDR_W-1:0] n_addr = '0;
  logic [CNT_W-1:0]  factor = '0;
  logic busy, Read_Enable, Write_Enable, Ld_data, Ld_p1_xi, en_M_addr;
  logic en_sum, sel_mult, en_stream, stop_empty, stop_Afull, done, clear;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  phase;
  logic [OUT_W-1:0]  out_cnt;

  intpol_ctrl_fsm #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .mode(mode), .bypass(bypass),
    .n_addr(n_addr), .factor(factor), .Empty(Empty), .Afull(Afull),
    .busy(busy), .Read_Enable(Read_Enable), .Write_Enable(Write_Enable),
    .Ld_data(Ld_data), .Ld_p1_xi(Ld_p1_xi), .en_M_addr(en_M_addr),
    .addr(addr), .phase(phase), .en_sum(en_sum), .sel_mult(sel_mult),
    .en_stream(en_stream), .stop_empty(stop_empty), .stop_Afull(stop_Afull),
    .done(done), .clear(clear), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // one record per expected done pulse
  typedef struct {
    int ld;
    int re;
    int oc;
  } rec_t;
  rec_t exp_q[$];

  int   done_seen = 0, ld_since = 0, re_since = 0, ld_j = 0, mon_l = 1;
  bit   mon_mode = 1'b0;
  logic prev_ld_eff = 1'b0, prev_stall = 1'b0, prev_strm_rd = 1'b0;
  logic [CNT_W-1:0] prev_phase = '0;

  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      chk("write_enable_delay", Write_Enable, prev_ld_eff);
      chk("clear_or", clear, start | done);
      if (prev_stall)   chk("stall_phase_hold", phase, prev_phase);
      if (prev_strm_rd) chk("prime_after_stream_read", Ld_p1_xi, 1);
      if (sel_mult) begin
        chk("interp_stop_afull", stop_Afull, mon_mode & Afull);
        chk("interp_ld_data", Ld_data, !(mon_mode & Afull));
      end
      if (en_stream) begin
        chk("stream_stop_empty", stop_empty, Empty);
        chk("stream_read", Read_Enable, !Empty);
      end
      if (mon_mode && !start && rstn && Read_Enable) chk("read_while_empty", Empty, 0);
      if (Ld_data) begin
        chk("ld_phase", phase, ld_j % mon_l);
        ld_j++;
        ld_since++;
      end
      if (Read_Enable) re_since++;
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 with no block pending");
        end else begin
          r = exp_q.pop_front();
          chk("blk_ld_count", ld_since, r.ld);
          chk("blk_read_count", re_since, r.re);
          chk("blk_out_cnt", out_cnt, r.oc);
          chk("blk_phase_zero", phase, 0);
        end
        ld_since = 0;
        done_seen++;
      end
      prev_ld_eff  = rstn & Ld_data;
      prev_stall   = rstn & !start & stop_Afull;
      prev_strm_rd = rstn & !start & en_stream & Read_Enable;
      prev_phase   = phase;
      if (start) begin
        mon_l    = (factor == 0) ? 1 : int'(factor);
        mon_mode = mode;
        ld_j     = 0;
        ld_since = 0;
        re_since = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_io();
    Empty = ($urandom_range(0, 9) < 3);
    Afull = ($urandom_range(0, 9) < 3);
  endtask

  task automatic wait_done(int target, bit m, bit b, int l);
    for (int c = 0; c < 3000 && done_seen < target; c++) begin
      rand_io();
      tick();
    end
    if (done_seen < target) begin
      chk("done_timeout", done_seen, target);
      exp_q.delete();
    end
    if (!m) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_out_cnt", out_cnt, b ? 0 : l);
      chk("idle_addr", addr, 0);
      tick();
    end
  endtask

  task automatic run_op(bit m, bit b, int n, int f, int nblk);
    int l, target;
    rec_t r;
    l = (f == 0) ? 1 : f;
    mode = m; bypass = b; n_addr = ADDR_W'(n); factor = CNT_W'(f); start = 1'b1;
    for (int k = 1; k <= nblk; k++) begin
      r.ld = b ? 0 : l;
      r.re = n + 1 + (k - 1);
      r.oc = b ? 0 : k * l - 1;
      exp_q.push_back(r);
    end
    target = done_seen + nblk;
    tick();
    start = 1'b0;
    wait_done(target, m, b, l);
  endtask

  initial begin
    rec_t r;
    int target, d0;
    bit m, b;
    // reset wins over a simultaneous start
    start = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_clear_follows_start", clear, 1);
    chk("rst_read", Read_Enable, 0);
    chk("rst_we", Write_Enable, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_addr", addr, 0);
    chk("rst_phase", phase, 0);
    chk("rst_done", done, 0);
    tick();
    start = 1'b0;
    rstn  = 1'b1;
    @(negedge clk);
    chk("rst_over_start_idle", busy, 0);
    tick();

    run_op(0, 0, 3, 4, 1);
    run_op(0, 0, 2, 0, 1);
    run_op(0, 1, 2, 5, 1);
    run_op(1, 0, 1, 2, 3);
    run_op(1, 0, 0, 0, 2);
    for (int i = 0; i < 12; i++) begin
      m = 1'($urandom_range(0, 1));
      b = m ? 1'b0 : ($urandom_range(0, 3) == 0);
      run_op(m, b, $urandom_range(0, 5), $urandom_range(0, 5), m ? $urandom_range(1, 3) : 1);
    end

    // abort mid-interpolation
    mode = 1'b0; bypass = 1'b0; n_addr = 1; factor = 6; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (Ld_data && phase == 2) break;
      tick();
    end
    chk("abort_point_reached", Ld_data && phase == 2, 1);
    n_addr = 0; factor = 2; start = 1'b1;
    r.ld = 2; r.re = 1; r.oc = 1;
    exp_q.push_back(r);
    target = done_seen + 1;
    tick();
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_clear", clear, 1);
    chk("abort_addr", addr, 0);
    chk("abort_phase", phase, 0);
    chk("abort_out_cnt", out_cnt, 0);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("abort_hold_busy", busy, 0);
    chk("abort_hold_out_cnt", out_cnt, 0);
    wait_done(target, 0, 0, 2);

    // bypass stream, then reset while reading
    mode = 1'b1; bypass = 1'b1; n_addr = 2; factor = 3; Empty = 1'b0; Afull = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (busy && !en_M_addr) break;
      tick();
    end
    chk("byp_strm_reached", busy && !en_M_addr, 1);
    for (int c = 0; c < 10; c++) begin
      rand_io();
      @(negedge clk);
      chk("byp_read", Read_Enable, !Empty && !Afull);
      chk("byp_stop_empty", stop_empty, Empty);
      chk("byp_stop_afull", stop_Afull, Afull);
      chk("byp_busy", busy, 1);
      tick();
    end
    Empty = 1'b0; Afull = 1'b0;
    @(negedge clk);
    chk("byp_read_before_rst", Read_Enable, 1);
    tick();
    rstn = 1'b0;
    d0 = done_seen;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_read", Read_Enable, 0);
    chk("post_rst_stops", {stop_empty, stop_Afull, en_stream, sel_mult, en_sum}, 0);
    chk("post_rst_strobes", {Write_Enable, Ld_data, Ld_p1_xi, en_M_addr, done, clear}, 0);
    chk("post_rst_counters", {addr, phase, out_cnt}, 0);
    chk("post_rst_no_done", done_seen, d0);
    tick();

    run_op(0, 0, 1, 3, 1);
    run_op(1, 0, 2, 4, 2);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
